// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command decoder and its byte timeout helper.
// Frame length depends on the UART_CMD_CHECKSUM_EN build option.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_HUNT   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ARG_LO = 3'd2,
        ST_ARG_HI = 3'd3,
        ST_CHK    = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
    localparam logic [1:0] ERR_CHECKSUM = 2'd2;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h5A;

    localparam int FRAME_LEN_CHK   = 5;
    localparam int FRAME_LEN_NOCHK = 4;

    // A good frame sums to zero modulo 256 over CMD, ARG_LO, ARG_HI and CHK.
    function automatic logic [7:0] frame_sum(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c, input logic [7:0] d);
        return a + b + c + d;
    endfunction

endpackage

// File: rtl/uart_byte_timeout.sv
// Inter-byte watchdog: counts clocks while enabled and pulses expired on the
// terminal count unless clear arrives in the same cycle.
module uart_byte_timeout #(
    parameter int TIMEOUT_CLOCKS = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CLOCKS > 2) ? $clog2(TIMEOUT_CLOCKS) : 1;
    localparam logic [CW-1:0] TERMINAL = CW'(TIMEOUT_CLOCKS - 1);

    logic [CW-1:0] r_count;
    logic          w_at_terminal;

    assign w_at_terminal = (r_count == TERMINAL);

    // Clock counter; wraps explicitly so non-power-of-two limits behave.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (enable) begin
            if (w_at_terminal) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CW'(1);
            end
        end else begin
            r_count <= r_count;
        end
    end

    assign expired = enable && !clear && w_at_terminal;

endmodule

// File: rtl/uart_cmd_decoder.sv
// Frames the UART RX byte stream into SYNC/CMD/ARG_LO/ARG_HI[/CHK] commands.
// Build option UART_CMD_CHECKSUM_EN adds the CHK byte and checksum test.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int          TIMEOUT_CLOCKS = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    output logic [7:0]  cmd_o,
    output logic [15:0] arg_o,
    output logic        cmd_valid_o,
    output logic        error_o,
    output logic [1:0]  err_code_o,
    output logic [7:0]  drop_count_o,
    output logic        busy_o
);

    state_t      r_state;
    state_t      w_state_next;

    logic [7:0]  r_cmd_sh;
    logic [7:0]  r_lo_sh;
    logic [7:0]  r_cmd;
    logic [15:0] r_arg;
    logic        r_cmd_valid;
    logic        r_error;
    logic [1:0]  r_err_code;
    logic [7:0]  r_drop;
    logic        r_busy;

    logic        w_expired;
    logic        w_tmo_clear;
    logic        w_tmo_enable;
    logic        w_complete;
    logic        w_fail;
    logic [1:0]  w_fail_code;
    logic        w_drop;
    logic        w_lat_cmd;
    logic        w_lat_lo;
    logic [15:0] w_done_arg;

`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]  r_hi_sh;
    logic        w_lat_hi;
    logic        w_sum_ok;

    assign w_sum_ok   = (frame_sum(r_cmd_sh, r_lo_sh, r_hi_sh, data_i) == 8'h00);
    assign w_done_arg = {r_hi_sh, r_lo_sh};
`else
    assign w_done_arg = {data_i, r_lo_sh};
`endif

    assign w_tmo_enable = (r_state != ST_HUNT);
    assign w_tmo_clear  = valid_i || (r_state == ST_HUNT);

    uart_byte_timeout #(
        .TIMEOUT_CLOCKS (TIMEOUT_CLOCKS)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (w_tmo_clear),
        .enable  (w_tmo_enable),
        .expired (w_expired)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and per-byte actions; expired can only fire without valid_i.
    always_comb begin
        w_state_next = r_state;
        w_complete   = 1'b0;
        w_fail       = 1'b0;
        w_fail_code  = ERR_NONE;
        w_drop       = 1'b0;
        w_lat_cmd    = 1'b0;
        w_lat_lo     = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
        w_lat_hi     = 1'b0;
`endif
        if (w_expired) begin
            w_state_next = ST_HUNT;
            w_fail       = 1'b1;
            w_fail_code  = ERR_TIMEOUT;
        end else if (valid_i) begin
            case (r_state)
                ST_HUNT: begin
                    if (data_i == SYNC_BYTE) begin
                        w_state_next = ST_CMD;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
                ST_CMD: begin
                    w_lat_cmd    = 1'b1;
                    w_state_next = ST_ARG_LO;
                end
                ST_ARG_LO: begin
                    w_lat_lo     = 1'b1;
                    w_state_next = ST_ARG_HI;
                end
                ST_ARG_HI: begin
`ifdef UART_CMD_CHECKSUM_EN
                    w_lat_hi     = 1'b1;
                    w_state_next = ST_CHK;
`else
                    w_complete   = 1'b1;
                    w_state_next = ST_HUNT;
`endif
                end
`ifdef UART_CMD_CHECKSUM_EN
                ST_CHK: begin
                    w_state_next = ST_HUNT;
                    if (w_sum_ok) begin
                        w_complete = 1'b1;
                    end else begin
                        w_fail      = 1'b1;
                        w_fail_code = ERR_CHECKSUM;
                    end
                end
`endif
                default: begin
                    w_state_next = ST_HUNT;
                end
            endcase
        end else begin
            w_state_next = r_state;
        end
    end

    // Shadow capture, output registers and drop counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cmd_sh    <= 8'h00;
            r_lo_sh     <= 8'h00;
`ifdef UART_CMD_CHECKSUM_EN
            r_hi_sh     <= 8'h00;
`endif
            r_cmd       <= 8'h00;
            r_arg       <= 16'h0000;
            r_cmd_valid <= 1'b0;
            r_error     <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_drop      <= 8'h00;
            r_busy      <= 1'b0;
        end else begin
            r_cmd_valid <= w_complete;
            r_error     <= w_fail;
            r_busy      <= (w_state_next != ST_HUNT);
            if (w_lat_cmd) begin
                r_cmd_sh <= data_i;
            end
            if (w_lat_lo) begin
                r_lo_sh <= data_i;
            end
`ifdef UART_CMD_CHECKSUM_EN
            if (w_lat_hi) begin
                r_hi_sh <= data_i;
            end
`endif
            if (w_complete) begin
                r_cmd <= r_cmd_sh;
                r_arg <= w_done_arg;
            end
            if (w_fail) begin
                r_err_code <= w_fail_code;
            end
            if (w_drop && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
        end
    end

    assign cmd_o        = r_cmd;
    assign arg_o        = r_arg;
    assign cmd_valid_o  = r_cmd_valid;
    assign error_o      = r_error;
    assign err_code_o   = r_err_code;
    assign drop_count_o = r_drop;
    assign busy_o       = r_busy;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: directed plan steps plus random frames, each cycle
// compared against a byte-list frame model. Honours UART_CMD_CHECKSUM_EN.
module tb_uart_cmd_decoder;
    import uart_cmd_pkg::*;

    localparam int TMO = 64;
`ifdef UART_CMD_CHECKSUM_EN
    localparam int FL = FRAME_LEN_CHK;
`else
    localparam int FL = FRAME_LEN_NOCHK;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  data_i = 8'h00;
    logic        valid_i = 1'b0;
    logic [7:0]  cmd_o;
    logic [15:0] arg_o;
    logic        cmd_valid_o;
    logic        error_o;
    logic [1:0]  err_code_o;
    logic [7:0]  drop_count_o;
    logic        busy_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: bytes collected so far in the current frame (0 = hunting).
    int m_pos, m_idle, m_cmd, m_arg, m_drop, m_code, m_cv, m_err;
    int m_buf [4];

    logic [7:0] f_cmd, f_lo, f_hi, f_chk, f_sum;
    int gap;

    uart_cmd_decoder #(
        .SYNC_BYTE      (8'h5A),
        .TIMEOUT_CLOCKS (TMO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .cmd_o        (cmd_o),
        .arg_o        (arg_o),
        .cmd_valid_o  (cmd_valid_o),
        .error_o      (error_o),
        .err_code_o   (err_code_o),
        .drop_count_o (drop_count_o),
        .busy_o       (busy_o)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic rst, input logic v, input logic [7:0] d);
        m_cv  = 0;
        m_err = 0;
        if (rst) begin
            m_pos = 0; m_idle = 0; m_cmd = 0; m_arg = 0; m_drop = 0; m_code = 0;
        end else if (v) begin
            m_idle = 0;
            if (m_pos == 0) begin
                if (d == 8'h5A) m_pos = 1;
                else if (m_drop < 255) m_drop++;
            end else begin
                m_buf[m_pos-1] = int'(d);
                m_pos++;
                if (m_pos == FL) begin
                    m_pos = 0;
                    if (FL == 4 || ((m_buf[0] + m_buf[1] + m_buf[2] + m_buf[3]) % 256) == 0) begin
                        m_cmd = m_buf[0];
                        m_arg = m_buf[2] * 256 + m_buf[1];
                        m_cv  = 1;
                    end else begin
                        m_err  = 1;
                        m_code = 2;
                    end
                end
            end
        end else if (m_pos != 0) begin
            if (m_idle == TMO - 1) begin
                m_err = 1; m_code = 1; m_pos = 0; m_idle = 0;
            end else begin
                m_idle++;
            end
        end
    endtask

    task automatic tick(input logic v, input logic [7:0] d);
        valid_i = v;
        data_i  = d;
        @(posedge clock);
        model(reset, v, d);
        #1;
        chk("cmd_valid", 16'(cmd_valid_o), 16'(m_cv));
        chk("error", 16'(error_o), 16'(m_err));
        chk("cmd", 16'(cmd_o), 16'(m_cmd));
        chk("arg", arg_o, 16'(m_arg));
        chk("err_code", 16'(err_code_o), 16'(m_code));
        chk("drop_count", 16'(drop_count_o), 16'(m_drop));
        chk("busy", 16'(busy_o), 16'(m_pos != 0));
        valid_i = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int idle);
        repeat (idle) tick(1'b0, 8'h00);
        tick(1'b1, b);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1'b0, 8'h00);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        tick(1'b0, 8'h00);
        tick(1'b0, 8'h00);
        reset = 1'b0;
        chk("reset_busy", 16'(busy_o), 16'h0000);

        // Widely spaced good frame.
        send(8'h5A, 0); send(8'h10, 60); send(8'h34, 60); send(8'h12, 60);
        if (FL == 5) send(8'hAA, 60);
        chk("tp1_cmd", 16'(cmd_o), 16'h0010);
        chk("tp1_arg", arg_o, 16'h1234);
        tick(1'b0, 8'h00);

        // Leading junk then a frame.
        send(8'h33, 0); send(8'h44, 0);
        chk("tp2_drop", 16'(drop_count_o), 16'h0002);
        send(8'h5A, 0); send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'hFA, 0);
        chk("tp2_cmd", 16'(cmd_o), 16'h0001);
        chk("tp2_arg", arg_o, 16'h0302);

        // Bad checksum (plain frame + junk in the 4-byte build), then a good frame.
        send(8'h5A, 0); send(8'h10, 0); send(8'h34, 0); send(8'h12, 0); send(8'hAB, 0);
`ifdef UART_CMD_CHECKSUM_EN
        chk("tp3_code", 16'(err_code_o), 16'h0002);
        chk("tp3_cmd_kept", 16'(cmd_o), 16'h0001);
`endif
        send(8'h5A, 0); send(8'h22, 0); send(8'h11, 0); send(8'h00, 0);
        if (FL == 5) send(8'hCD, 0);
        chk("tp3_next_cmd", 16'(cmd_o), 16'h0022);

        // Silence after CMD: timeout on the 64th idle clock after the byte.
        send(8'h5A, 0); send(8'h10, 0);
        repeat (TMO - 1) tick(1'b0, 8'h00);
        chk("tp4_no_err_early", 16'(error_o), 16'h0000);
        tick(1'b0, 8'h00);
        chk("tp4_err", 16'(error_o), 16'h0001);
        chk("tp4_code", 16'(err_code_o), 16'h0001);
        chk("tp4_busy", 16'(busy_o), 16'h0000);
        tick(1'b0, 8'h00);

        // Byte on the terminal count continues the frame.
        send(8'h5A, 0); send(8'h10, 0); send(8'h34, TMO - 1);
        chk("tp4_term_busy", 16'(busy_o), 16'h0001);
        send(8'h12, TMO - 1);
        if (FL == 5) send(8'hAA, TMO - 1);
        chk("tp4_term_cv", 16'(cmd_valid_o), 16'h0001);

        // Reset mid-frame, then a full frame.
        send(8'h5A, 0); send(8'h10, 0); send(8'h34, 0);
        do_reset();
        chk("tp5_cmd_zero", 16'(cmd_o), 16'h0000);
        chk("tp5_err_zero", 16'(error_o), 16'h0000);
        send(8'h5A, 0); send(8'h7F, 0); send(8'hCD, 0); send(8'hAB, 0);
        if (FL == 5) send(8'h09, 0);
        chk("tp6_cmd", 16'(cmd_o), 16'h007F);
        chk("tp6_arg", arg_o, 16'hABCD);
        send(8'h00, 0);
        chk("tp6_drop", 16'(drop_count_o), 16'h0001);

        // Random frames: good/bad checksums, junk, zero gaps and boundary gaps.
        for (int f = 0; f < 150; f++) begin
            f_cmd = 8'($urandom);
            f_lo  = 8'($urandom);
            f_hi  = 8'($urandom);
            f_sum = f_cmd + f_lo + f_hi;
            f_chk = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (8'h00 - f_sum);
            if ($urandom_range(0, 3) == 0) send(8'($urandom), $urandom_range(0, 2));
            for (int k = 0; k < FL; k++) begin
                gap = ($urandom_range(0, 19) == 0) ? $urandom_range(TMO - 4, TMO + 4)
                                                   : $urandom_range(0, 3);
                case (k)
                    0: send(8'h5A, gap);
                    1: send(f_cmd, gap);
                    2: send(f_lo, gap);
                    3: send(f_hi, gap);
                    default: send(f_chk, gap);
                endcase
            end
        end

        // Saturating drop counter.
        for (int j = 0; j < 300; j++) begin
            f_cmd = 8'($urandom);
            if (f_cmd == 8'h5A) f_cmd = 8'h00;
            send(f_cmd, 0);
        end
        chk("tp7_drop_sat", 16'(drop_count_o), 16'h00FF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
